hopfield_recall_sequencer: RTL and testbench

- Sequences the recall (UPDATING) phase of the Hopfield network with asynchronous, row-by-row neuron updates.
- For each neuron i it streams row i of the weight memory through a serial multiply-accumulate against the current neuron state vector. It then decides the new state and issues a single-neuron write.
- It repeats full sweeps until one sweep produces no change (converged) or a sweep limit is reached (timeout).
- Sits between the network controller (start/abort) and the neuron/weight datapath.

---
 rtl/hopfield_recall_sequencer_if.sv | 35 +++
 rtl/hopfield_recall_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_hopfield_recall_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hopfield_recall_sequencer_if.sv
// Bundle between the recall sequencer, the network controller and the neuron/weight datapath.
// "slave" is the sequencer's view; "master" is the controller plus datapath side.
interface hopfield_recall_sequencer_if #(
    parameter int N_NEURONS = 16,
    parameter int IDX_W     = 4,
    parameter int W_WIDTH   = 8,
    parameter int SWP_W     = 4
);
    logic                 start;
    logic                 abort;
    logic [N_NEURONS-1:0] state_vec;
    logic                 w_rd_en;
    logic [IDX_W-1:0]     w_row;
    logic [IDX_W-1:0]     w_col;
    logic [W_WIDTH-1:0]   w_data;
    logic                 upd_en;
    logic [IDX_W-1:0]     upd_idx;
    logic                 upd_val;
    logic                 busy;
    logic                 converged;
    logic                 timeout;
    logic [SWP_W-1:0]     sweep_cnt;

    modport slave (
        input  start, abort, state_vec, w_data,
        output w_rd_en, w_row, w_col, upd_en, upd_idx, upd_val,
               busy, converged, timeout, sweep_cnt
    );

    modport master (
        output start, abort, state_vec, w_data,
        input  w_rd_en, w_row, w_col, upd_en, upd_idx, upd_val,
               busy, converged, timeout, sweep_cnt
    );
endinterface

// File: rtl/hopfield_recall_sequencer.sv
// Asynchronous (row-by-row) Hopfield recall: serial MAC of each weight row against the
// live state vector, single-neuron write-back, repeated sweeps until no change or sweep limit.
module hopfield_recall_sequencer #(
    parameter int N_NEURONS  = 16,
    parameter int IDX_W      = 4,
    parameter int W_WIDTH    = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int MAX_SWEEPS = 8,
    parameter int SWP_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    hopfield_recall_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DRAIN  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W-1:0]     IDX_ZERO    = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]     IDX_ONE     = IDX_W'(1);
    localparam logic [SWP_W-1:0]     SWP_ZERO    = {SWP_W{1'b0}};
    localparam logic [SWP_W-1:0]     SWP_ONE     = SWP_W'(1);
    localparam logic [SWP_W-1:0]     SWEEP_LIMIT = SWP_W'(MAX_SWEEPS);
    localparam logic [ACC_WIDTH-1:0] ACC_ZERO    = {ACC_WIDTH{1'b0}};

    state_t                 state_q;
    logic                   w_rd_en_q;
    logic [IDX_W-1:0]       w_row_q;
    logic [IDX_W-1:0]       w_col_q;
    logic                   rd_vld_q;
    logic [IDX_W-1:0]       col_d_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic                   changed_q;
    logic                   upd_en_q;
    logic [IDX_W-1:0]       upd_idx_q;
    logic                   upd_val_q;
    logic                   busy_q;
    logic                   converged_q;
    logic                   timeout_q;
    logic [SWP_W-1:0]       sweep_cnt_q;

    logic [ACC_WIDTH-1:0]   term_s;
    logic [ACC_WIDTH-1:0]   acc_d;
    logic                   upd_val_d;
    logic                   changed_d;
    logic [SWP_W-1:0]       sweep_cnt_d;

    // Accumulate the returning weight (diagonal masked) and pre-decide the neuron's new value.
    always_comb begin
        term_s = ACC_ZERO;
        if (rd_vld_q && (col_d_q != w_row_q)) begin
            term_s = {{(ACC_WIDTH-W_WIDTH){bus.w_data[W_WIDTH-1]}}, bus.w_data};
        end else begin
            term_s = ACC_ZERO;
        end
        if (bus.state_vec[col_d_q]) begin
            acc_d = acc_q + term_s;
        end else begin
            acc_d = acc_q - term_s;
        end
        if (acc_d == ACC_ZERO) begin
            upd_val_d = bus.state_vec[w_row_q];
        end else begin
            upd_val_d = ~acc_d[ACC_WIDTH-1];
        end
        changed_d   = changed_q | (upd_val_d != bus.state_vec[w_row_q]);
        sweep_cnt_d = sweep_cnt_q + SWP_ONE;
    end

    // Recall FSM; w_row/w_col double as the row and column counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            w_rd_en_q   <= 1'b0;
            w_row_q     <= IDX_ZERO;
            w_col_q     <= IDX_ZERO;
            rd_vld_q    <= 1'b0;
            col_d_q     <= IDX_ZERO;
            acc_q       <= ACC_ZERO;
            changed_q   <= 1'b0;
            upd_en_q    <= 1'b0;
            upd_idx_q   <= IDX_ZERO;
            upd_val_q   <= 1'b0;
            busy_q      <= 1'b0;
            converged_q <= 1'b0;
            timeout_q   <= 1'b0;
            sweep_cnt_q <= SWP_ZERO;
        end else begin
            rd_vld_q <= w_rd_en_q;
            col_d_q  <= w_col_q;
            if (bus.abort && (state_q != S_IDLE)) begin
                state_q     <= S_IDLE;
                w_rd_en_q   <= 1'b0;
                upd_en_q    <= 1'b0;
                busy_q      <= 1'b0;
                converged_q <= 1'b0;
                timeout_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (bus.start) begin
                            state_q     <= S_FETCH;
                            w_rd_en_q   <= 1'b1;
                            w_row_q     <= IDX_ZERO;
                            w_col_q     <= IDX_ZERO;
                            acc_q       <= ACC_ZERO;
                            changed_q   <= 1'b0;
                            sweep_cnt_q <= SWP_ZERO;
                            busy_q      <= 1'b1;
                            converged_q <= 1'b0;
                            timeout_q   <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        acc_q <= acc_d;
                        if (w_col_q == LAST_IDX) begin
                            state_q   <= S_DRAIN;
                            w_rd_en_q <= 1'b0;
                        end else begin
                            w_col_q <= w_col_q + IDX_ONE;
                        end
                    end
                    S_DRAIN: begin
                        acc_q     <= acc_d;
                        state_q   <= S_UPDATE;
                        upd_en_q  <= 1'b1;
                        upd_idx_q <= w_row_q;
                        upd_val_q <= upd_val_d;
                        changed_q <= changed_d;
                    end
                    S_UPDATE: begin
                        upd_en_q <= 1'b0;
                        if (w_row_q != LAST_IDX) begin
                            state_q   <= S_FETCH;
                            w_rd_en_q <= 1'b1;
                            w_row_q   <= w_row_q + IDX_ONE;
                            w_col_q   <= IDX_ZERO;
                            acc_q     <= ACC_ZERO;
                        end else begin
                            sweep_cnt_q <= sweep_cnt_d;
                            if (!changed_q) begin
                                state_q     <= S_DONE;
                                busy_q      <= 1'b0;
                                converged_q <= 1'b1;
                            end else if (sweep_cnt_d == SWEEP_LIMIT) begin
                                state_q   <= S_DONE;
                                busy_q    <= 1'b0;
                                timeout_q <= 1'b1;
                            end else begin
                                state_q   <= S_FETCH;
                                w_rd_en_q <= 1'b1;
                                w_row_q   <= IDX_ZERO;
                                w_col_q   <= IDX_ZERO;
                                acc_q     <= ACC_ZERO;
                                changed_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        w_rd_en_q <= 1'b0;
                        upd_en_q  <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.w_rd_en   = w_rd_en_q;
    assign bus.w_row     = w_row_q;
    assign bus.w_col     = w_col_q;
    // An abort landing on the UPDATE cycle must kill the write in that same cycle.
    assign bus.upd_en    = upd_en_q & ~bus.abort;
    assign bus.upd_idx   = upd_idx_q;
    assign bus.upd_val   = upd_val_q;
    assign bus.busy      = busy_q;
    assign bus.converged = converged_q;
    assign bus.timeout   = timeout_q;
    assign bus.sweep_cnt = sweep_cnt_q;
endmodule

// File: tb/tb_hopfield_recall_sequencer.sv
// Directed bench: a 4-neuron instance for tie/Hebbian/abort/reset cases and a
// 2-neuron, 2-sweep instance for the oscillating timeout case.
module tb_hopfield_recall_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hopfield_recall_sequencer_if #(.N_NEURONS(4), .IDX_W(2), .W_WIDTH(8), .SWP_W(4)) bus_a ();
    hopfield_recall_sequencer_if #(.N_NEURONS(2), .IDX_W(1), .W_WIDTH(8), .SWP_W(2)) bus_b ();

    hopfield_recall_sequencer #(
        .N_NEURONS(4), .IDX_W(2), .W_WIDTH(8), .ACC_WIDTH(16), .MAX_SWEEPS(8), .SWP_W(4)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

    hopfield_recall_sequencer #(
        .N_NEURONS(2), .IDX_W(1), .W_WIDTH(8), .ACC_WIDTH(16), .MAX_SWEEPS(2), .SWP_W(2)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    logic [7:0] wmem_a [0:3][0:3];
    logic [7:0] wmem_b [0:1][0:1];
    logic [3:0] sv_a, sv_init_a;
    logic [1:0] sv_b, sv_init_b;
    logic       load_a, load_b;

    // Weight memory with one-cycle read latency and neuron state register for each instance.
    always @(posedge clk) begin
        if (rst) bus_a.w_data <= 8'h00;
        else if (bus_a.w_rd_en) bus_a.w_data <= wmem_a[bus_a.w_row][bus_a.w_col];
        if (rst) bus_b.w_data <= 8'h00;
        else if (bus_b.w_rd_en) bus_b.w_data <= wmem_b[bus_b.w_row][bus_b.w_col];
        if (load_a) sv_a <= sv_init_a;
        else if (bus_a.upd_en) sv_a[bus_a.upd_idx] <= bus_a.upd_val;
        if (load_b) sv_b <= sv_init_b;
        else if (bus_b.upd_en) sv_b[bus_b.upd_idx] <= bus_b.upd_val;
    end
    assign bus_a.state_vec = sv_a;
    assign bus_b.state_vec = sv_b;

    int n_checks;
    int n_fail;
    int cyc;
    int t0;
    int ua_idx[$], ua_val[$], ua_cyc[$];
    int ub_idx[$], ub_val[$];
    logic [7:0] exp_bits;
    int p[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (bus_a.upd_en === 1'b1) begin
                ua_idx.push_back(int'(bus_a.upd_idx));
                ua_val.push_back(int'(bus_a.upd_val));
                ua_cyc.push_back(cyc);
            end
            if (bus_b.upd_en === 1'b1) begin
                ub_idx.push_back(int'(bus_b.upd_idx));
                ub_val.push_back(int'(bus_b.upd_val));
            end
        end
    endtask

    task automatic clear_logs();
        ua_idx.delete(); ua_val.delete(); ua_cyc.delete();
        ub_idx.delete(); ub_val.delete();
    endtask

    task automatic load_state_a(input logic [3:0] v);
        sv_init_a = v;
        load_a    = 1'b1;
        step(1);
        load_a    = 1'b0;
    endtask

    task automatic check_zero_a(input string tag);
        chk({tag, "_rd_en"}, bus_a.w_rd_en, 0);
        chk({tag, "_row"}, bus_a.w_row, 0);
        chk({tag, "_col"}, bus_a.w_col, 0);
        chk({tag, "_upd_en"}, bus_a.upd_en, 0);
        chk({tag, "_upd_idx"}, bus_a.upd_idx, 0);
        chk({tag, "_upd_val"}, bus_a.upd_val, 0);
        chk({tag, "_busy"}, bus_a.busy, 0);
        chk({tag, "_conv"}, bus_a.converged, 0);
        chk({tag, "_tmo"}, bus_a.timeout, 0);
        chk({tag, "_swp"}, bus_a.sweep_cnt, 0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0;
        load_a = 1'b0; load_b = 1'b0;
        sv_init_a = 4'b0000; sv_init_b = 2'b00;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) wmem_a[i][j] = 8'h00;
        wmem_b[0][0] = 8'h00; wmem_b[0][1] = 8'h01;
        wmem_b[1][0] = 8'hFF; wmem_b[1][1] = 8'h00;

        // Reset state
        step(3);
        check_zero_a("rst_a");
        chk("rst_b_busy", bus_b.busy, 0);
        chk("rst_b_swp", bus_b.sweep_cnt, 0);
        rst = 1'b0;
        step(1);
        chk("idle_busy", bus_a.busy, 0);

        // All-zero weights: every row ties and keeps its bit, converges after one sweep
        load_state_a(4'b0110);
        clear_logs();
        bus_a.start = 1'b1; t0 = cyc;
        step(1);
        bus_a.start = 1'b0;
        chk("t1_busy_t1", bus_a.busy, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step(1);
            chk($sformatf("t1_rd_en_c%0d", k), bus_a.w_rd_en, 1);
            chk($sformatf("t1_col_c%0d", k), bus_a.w_col, k);
            chk($sformatf("t1_row_c%0d", k), bus_a.w_row, 0);
        end
        step(1);
        chk("t1_drain_rd_en", bus_a.w_rd_en, 0);
        chk("t1_drain_upd_en", bus_a.upd_en, 0);
        step(1);
        chk("t1_upd_rd_en", bus_a.w_rd_en, 0);
        chk("t1_upd_en", bus_a.upd_en, 1);
        chk("t1_upd_idx", bus_a.upd_idx, 0);
        step(18);
        chk("t1_conv_t24", bus_a.converged, 0);
        chk("t1_busy_t24", bus_a.busy, 1);
        step(1);
        chk("t1_conv_t25", bus_a.converged, 1);
        chk("t1_tmo_t25", bus_a.timeout, 0);
        chk("t1_busy_t25", bus_a.busy, 0);
        chk("t1_swp_t25", bus_a.sweep_cnt, 1);
        chk("t1_nupd", ua_val.size(), 4);
        exp_bits = 8'h06;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_val%0d", i), ua_val[i], exp_bits[i]);
            chk($sformatf("t1_idx%0d", i), ua_idx[i], i);
            chk($sformatf("t1_ucyc%0d", i), ua_cyc[i] - t0, 6 * (i + 1));
        end
        chk("t1_state", sv_a, 4'b0110);

        // Hebbian weights for p=(+1,-1,+1,-1); start 1101 flips only neuron 3
        p = '{1, -1, 1, -1};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                wmem_a[i][j] = (i == j) ? 8'h00 : 8'(p[i] * p[j]);
        load_state_a(4'b1101);
        clear_logs();
        bus_a.start = 1'b1; t0 = cyc;
        step(1);
        bus_a.start = 1'b0;
        step(47);
        chk("t2_conv_t48", bus_a.converged, 0);
        step(1);
        chk("t2_conv_t49", bus_a.converged, 1);
        chk("t2_tmo_t49", bus_a.timeout, 0);
        chk("t2_swp_t49", bus_a.sweep_cnt, 2);
        chk("t2_nupd", ua_val.size(), 8);
        exp_bits = 8'b0101_0101;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_val%0d", i), ua_val[i], exp_bits[i]);
            chk($sformatf("t2_idx%0d", i), ua_idx[i], i % 4);
        end
        chk("t2_state", sv_a, 4'b0101);
        step(3);
        chk("t2_conv_held", bus_a.converged, 1);
        chk("t2_swp_held", bus_a.sweep_cnt, 2);

        // Abort on the UPDATE cycle of row 1, with an ignored start pulse mid-FETCH
        load_state_a(4'b1101);
        clear_logs();
        bus_a.start = 1'b1; t0 = cyc;
        step(1);
        bus_a.start = 1'b0;
        step(2);
        bus_a.start = 1'b1;
        step(1);
        bus_a.start = 1'b0;
        step(2);
        chk("t3_row0_upd_en", bus_a.upd_en, 1);
        chk("t3_row0_upd_idx", bus_a.upd_idx, 0);
        step(6);
        chk("t3_row1_upd_en", bus_a.upd_en, 1);
        chk("t3_row1_upd_idx", bus_a.upd_idx, 1);
        bus_a.abort = 1'b1;
        #1;
        chk("t3_abort_upd_en", bus_a.upd_en, 0);
        step(1);
        bus_a.abort = 1'b0;
        chk("t3_busy", bus_a.busy, 0);
        chk("t3_conv", bus_a.converged, 0);
        chk("t3_tmo", bus_a.timeout, 0);
        chk("t3_rd_en", bus_a.w_rd_en, 0);
        step(2);
        chk("t3_idle_busy", bus_a.busy, 0);
        chk("t3_state", sv_a, 4'b1101);

        // Reset in sweep 2 FETCH, then a fresh recall from row 0
        clear_logs();
        bus_a.start = 1'b1; t0 = cyc;
        step(1);
        bus_a.start = 1'b0;
        step(26);
        chk("t4_swp_pre", bus_a.sweep_cnt, 1);
        chk("t4_col_pre", bus_a.w_col, 2);
        chk("t4_rd_en_pre", bus_a.w_rd_en, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_zero_a("t4_post_rst");
        step(1);
        chk("t4_idle_busy", bus_a.busy, 0);
        clear_logs();
        bus_a.start = 1'b1; t0 = cyc;
        step(1);
        bus_a.start = 1'b0;
        chk("t4_new_row", bus_a.w_row, 0);
        chk("t4_new_col", bus_a.w_col, 0);
        chk("t4_new_rd_en", bus_a.w_rd_en, 1);
        chk("t4_new_swp", bus_a.sweep_cnt, 0);
        step(24);
        chk("t4_conv", bus_a.converged, 1);
        chk("t4_swp", bus_a.sweep_cnt, 1);
        chk("t4_state", sv_a, 4'b0101);

        // Two-neuron asymmetric weights oscillate until the 2-sweep limit
        sv_init_b = 2'b11;
        load_b    = 1'b1;
        step(1);
        load_b    = 1'b0;
        clear_logs();
        bus_b.start = 1'b1; t0 = cyc;
        step(1);
        bus_b.start = 1'b0;
        step(15);
        chk("t5_tmo_t16", bus_b.timeout, 0);
        chk("t5_busy_t16", bus_b.busy, 1);
        step(1);
        chk("t5_tmo_t17", bus_b.timeout, 1);
        chk("t5_conv_t17", bus_b.converged, 0);
        chk("t5_swp_t17", bus_b.sweep_cnt, 2);
        chk("t5_busy_t17", bus_b.busy, 0);
        chk("t5_nupd", ub_val.size(), 4);
        exp_bits = 8'b0000_1001;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_val%0d", i), ub_val[i], exp_bits[i]);
            chk($sformatf("t5_idx%0d", i), ub_idx[i], i % 2);
        end
        chk("t5_state", sv_b, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
